clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
Parametrised, runtime-programmable successor to the fixed power-of-two divider. It generates N_CH independent clock-enable ticks and 50%-duty square outputs from clock_50m. Divisors are arbitrary integers, not only 2^n, and can be reconfigured through a valid/ready handshake. A new divisor takes effect only at a period boundary, so output periods never glitch. Feeds keypad-scan, FND-multiplex and other slow-rate logic as enables on the clock_50m domain rather than as derived clocks.

Parameters:
N_CH, 2, number of independent channels (1..8)
CNT_W, 24, divisor/counter width in bits
DEF_DIV, 24'd1048576, divisor loaded into every channel at reset (2^20; same sw rate as the legacy block)
CH_W, 3, width of cfg_ch (must satisfy 2^CH_W >= N_CH)

Ports:
clock_50m  in  1  board clock, 50 MHz
rst  in  1  reset, asynchronous, active-low
sync_clr  in  1  synchronous phase-align: restarts all channels together
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready at a rising edge
cfg_ch  in  CH_W  target channel
cfg_div  in  CNT_W  new divisor; 0 = channel disabled
tick  out  N_CH  one-cycle enable pulse per channel period
sq  out  N_CH  square wave, period 2*div cycles, 50% duty
busy  out  N_CH  channel has a staged (pending) update

Behaviour:
- Reset (rst=0, async): count=0, div_active=DEF_DIV, pending=0. All outputs are registered and reset to 0: tick, sq, busy. cfg_ready is combinational and not reset-gated.
- Per channel, div_active=D>0:
  - count increments 0..D-1.
  - On the edge where count==D-1: count<=0, tick<=1 for exactly one cycle, sq<=~sq.
  - First tick is high in the cycle following the D-th rising edge after reset release. It then repeats every D cycles.
  - D=1: tick is constantly high; sq toggles every cycle (25 MHz).
- D=0 (disabled): count held at 0, tick=0, sq forced to 0.
- cfg_ready = (cfg_ch < N_CH) ? ~busy[cfg_ch] : 1.
- Out-of-range cfg_ch is accepted and dropped, with no state change.
- On accept: staged_div[ch]<=cfg_div and busy[ch]<=1 from the next cycle.
- Apply rule:
  - If busy and count==D-1 (wrap edge): div_active<=staged_div, busy<=0, count<=0. The old period's final tick and sq toggle still occur on that edge.
  - If busy and the channel is disabled: apply on the next edge.
- New divisor is 0 at a wrap: the final tick is still emitted and the sq toggle is suppressed; sq<=0 on that edge.
- Accept and wrap on the same edge, channel not busy: the value is staged only. It is applied at the following wrap, never in the same edge.
- sync_clr=1:
  - For every channel: count<=0, sq<=0, tick<=0 that edge.
  - busy/staged are preserved; a pending update on a busy enabled channel is applied immediately on this edge.
  - sync_clr has priority over wrap.
  - A cfg handshake in the same cycle is still accepted.
- Arithmetic is unsigned. count compares against div_active-1 computed in CNT_W bits; D=0 is special-cased first, so there is no underflow.
- Latency from cfg accept to new period start: remaining cycles of the current period plus 1.

Decomposition:
- Shared package/header clock_enable_pkg holds:
  - default CNT_W
  - DEF_DIV values for the standard rates (SW_DIV=2^20, FND_DIV=2^16)
  - macro for CH_W = clog2(N_CH)
- One sub-module, clock_enable_chan: the counter, staged register, busy, tick and sq for one channel, with cfg_we, cfg_div and sync_clr inputs.
- The top handles cfg decode and cfg_ready muxing, and instantiates N_CH channels in a generate loop.

Test Plan:
- Reset release with N_CH=2, DEF_DIV overridden to 4 -> tick[0], tick[1] high on cycles 4, 8, 12; sq toggles at the same edges (period 8); busy=0.
- Write ch0 div=3 while count=1 of a D=4 period -> cfg_ready drops for ch0 next cycle; tick at cycle 4 (old period), then at +3, +6; busy clears on the wrap edge.
- Write ch1 div=0 -> the final tick at the next wrap, then tick=0 and sq=0 persist. Write ch1 div=1 -> applied next edge, tick constantly high, sq toggles every cycle.
- Staging and simultaneous events:
  - Second write to a busy channel -> cfg_ready=0 and the value is ignored until busy clears.
  - Write with cfg_ch=3 at N_CH=2 -> accepted, no effect.
  - Write arriving on a wrap edge -> applied one period later.
- Channels at D=5 and D=7 mid-period, assert sync_clr one cycle -> both sq=0, no tick that cycle, next ticks at +5 and +7 from clear.
- Assert rst low mid-period with a pending update -> all outputs 0 immediately; after release div_active=DEF_DIV and the staged value is discarded.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared constants for the clock-enable generator family: default counter
// width, standard divisors for the slow-rate consumers, and a channel-index width helper.
package clock_enable_pkg;

  localparam int          DEF_CNT_W = 24;
  localparam logic [23:0] SW_DIV    = 24'd1048576;  // keypad/switch scan rate
  localparam logic [23:0] FND_DIV   = 24'd65536;    // FND multiplex rate

  // Minimum cfg_ch width that can address n_ch channels (never narrower than 1 bit).
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_enable_chan.sv
// One programmable clock-enable channel: period counter, staged divisor with
// busy flag, registered tick pulse and 50%-duty square output.
module clock_enable_chan
  import clock_enable_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(SW_DIV)
) (
  input  logic             clock_50m,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             sq,
  output logic             busy
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] staged_q, staged_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             disabled;
  logic             wrap;

  // Divisor 0 is tested first so div_q - 1 never underflows into a live compare.
  assign disabled = (div_q == '0);
  assign wrap     = !disabled && (count_q == (div_q - CNT_W'(1)));

  always_comb begin
    count_d  = count_q;
    div_d    = div_q;
    staged_d = staged_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;

    if (sync_clr) begin
      count_d = '0;
      sq_d    = 1'b0;
      if (busy_q) begin
        div_d  = staged_q;
        busy_d = 1'b0;
      end
    end else if (disabled) begin
      count_d = '0;
      sq_d    = 1'b0;
      if (busy_q) begin
        div_d  = staged_q;
        busy_d = 1'b0;
      end
    end else if (wrap) begin
      // The closing tick of the old period is always emitted; a switch to
      // divisor 0 parks sq low instead of toggling it.
      count_d = '0;
      tick_d  = 1'b1;
      sq_d    = (busy_q && (staged_q == '0)) ? 1'b0 : ~sq_q;
      if (busy_q) begin
        div_d  = staged_q;
        busy_d = 1'b0;
      end
    end else begin
      count_d = count_q + CNT_W'(1);
    end

    // A write only lands while idle, so it can never be applied on its own edge.
    if (cfg_we && !busy_q) begin
      staged_d = cfg_div;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      div_q    <= DEF_DIV;
      staged_q <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      div_q    <= div_d;
      staged_q <= staged_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign busy = busy_q;

endmodule

// File: rtl/clock_enable_gen.sv
// N_CH-channel programmable clock-enable generator: decodes the cfg handshake
// to one channel and muxes cfg_ready from that channel's busy flag.
module clock_enable_gen
  import clock_enable_pkg::*;
#(
  parameter int               N_CH    = 2,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(SW_DIV),
  parameter int               CH_W    = 3
) (
  input  logic             clock_50m,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  busy
);

  localparam int N_IDX = 1 << CH_W;

  logic [N_IDX-1:0] busy_ext;
  logic             cfg_accept;

  // Unused channel indices read as idle, so out-of-range writes are accepted and dropped.
  always_comb begin
    busy_ext           = '0;
    busy_ext[N_CH-1:0] = busy;
  end

  assign cfg_ready  = ~busy_ext[cfg_ch];
  assign cfg_accept = cfg_valid & cfg_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_accept && (cfg_ch == CH_W'(gi));

      clock_enable_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clock_50m (clock_50m),
        .rst       (rst),
        .sync_clr  (sync_clr),
        .cfg_we    (ch_we),
        .cfg_div   (cfg_div),
        .tick      (tick[gi]),
        .sq        (sq[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised scoreboard bench for clock_enable_gen: an edge-counting reference
// model predicts tick/sq/busy/cfg_ready and a negedge monitor checks them.
module tb_clock_enable_gen;

  localparam int N_CH  = 2;
  localparam int CNT_W = 24;
  localparam int CH_W  = 3;
  localparam int DEFD  = 4;

  logic             clock_50m = 1'b0;
  logic             rst;
  logic             sync_clr;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  busy;

  always #10 clock_50m = ~clock_50m;

  clock_enable_gen #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (24'd4),
    .CH_W    (CH_W)
  ) dut (
    .clock_50m (clock_50m),
    .rst       (rst),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq),
    .busy      (busy)
  );

  typedef struct {
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sq;
    logic [N_CH-1:0] busy;
    logic            ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: a period starts at edge m_org; edge n closes a period
  // whenever (n - m_org) is a multiple of the divisor.
  int m_n;
  int m_div[N_CH];
  int m_org[N_CH];
  int m_staged[N_CH];
  bit m_busy[N_CH];
  bit m_sq[N_CH];
  bit m_tick[N_CH];

  function automatic void model_reset();
    m_n = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_div[c] = DEFD; m_org[c] = 0; m_staged[c] = 0;
      m_busy[c] = 0; m_sq[c] = 0; m_tick[c] = 0;
    end
  endfunction

  function automatic void model_apply(input int c);
    if (m_busy[c]) begin
      m_div[c]  = m_staged[c];
      m_busy[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit sc, input bit acc, input int ch, input int dv);
    m_n++;
    for (int c = 0; c < N_CH; c++) begin
      m_tick[c] = 0;
      if (sc || m_div[c] == 0) begin
        m_org[c] = m_n;
        m_sq[c]  = 0;
        model_apply(c);
      end else if ((m_n - m_org[c]) % m_div[c] == 0) begin
        m_tick[c] = 1;
        if (m_busy[c]) begin
          m_sq[c]  = (m_staged[c] == 0) ? 1'b0 : !m_sq[c];
          m_org[c] = m_n;
          model_apply(c);
        end else begin
          m_sq[c] = !m_sq[c];
        end
      end
      if (acc && ch == c) begin
        m_staged[c] = dv;
        m_busy[c]   = 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Drive one cycle's inputs just after the edge, predict, then step the model.
  task automatic cycle(input bit r, input bit sc, input bit v, input int ch, input int dv);
    exp_t e;
    @(posedge clock_50m);
    #1;
    cyc++;
    rst       = r;
    sync_clr  = sc;
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(dv);
    if (!r) model_reset();
    for (int c = 0; c < N_CH; c++) begin
      e.tick[c] = m_tick[c];
      e.sq[c]   = m_sq[c];
      e.busy[c] = m_busy[c];
    end
    e.ready = (ch < N_CH) ? !m_busy[ch] : 1'b1;
    exp_q.push_back(e);
    if (v)
      $display("cfg cycle=%0d ch=%0d div=%0d accepted=%0b", cyc, ch, dv, e.ready);
    if (r) model_edge(sc, v && e.ready, ch, dv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  always @(negedge clock_50m) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("tick",      8'(tick),      8'(mon_e.tick));
      check("sq",        8'(sq),        8'(mon_e.sq));
      check("busy",      8'(busy),      8'(mon_e.busy));
      check("cfg_ready", 8'(cfg_ready), 8'(mon_e.ready));
    end
  end

  initial begin
    rst = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    idle(14);                       // ticks on edges 4, 8, 12
    cycle(1, 0, 1, 0, 3);           // ch0 -> 3 mid-period
    cycle(1, 0, 1, 0, 9);           // refused while busy
    idle(10);
    cycle(1, 0, 1, 1, 0);           // ch1 disabled at next wrap
    idle(8);
    cycle(1, 0, 1, 1, 1);           // ch1 -> 1 on next edge
    idle(6);
    cycle(1, 0, 1, 3, 7);           // out-of-range channel
    idle(2);
    cycle(1, 0, 1, 0, 5);
    cycle(1, 0, 1, 1, 7);
    idle(16);
    cycle(1, 1, 0, 0, 0);           // phase-align both channels
    idle(16);
    cycle(1, 0, 1, 0, 2);           // pending update then reset
    idle(1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      automatic bit r  = ($urandom_range(0, 199) != 0);
      automatic bit sc = ($urandom_range(0, 39) == 0);
      automatic bit v  = ($urandom_range(0, 2) == 0);
      automatic int ch = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 3));
      automatic int dv = int'($urandom_range(0, 9));
      cycle(r, sc, v, ch, dv);
    end

    @(negedge clock_50m);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
